// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers for the divider and multiplier datapaths.
//   shift_amt  : binary-point alignment shift for a quotient/product format
//   sat_signed : clamp a wide signed value to a narrower signed width
//   div_state_e: divider sequencing states
package fixed_point_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic signed [63:0] value;
        logic               ovf;
    } sat_res_t;

    // Left shift applied to the numerator so the integer quotient lands
    // directly on the output binary point.
    function automatic int shift_amt(input int np, input int dp, input int op);
        return dp + op - np;
    endfunction

    // Width must be in 2..63; the result occupies the low 'width' bits.
    function automatic sat_res_t sat_signed(input logic signed [63:0] value,
                                            input int width);
        sat_res_t           r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            r.value = hi;
            r.ovf   = 1'b1;
        end else if (value < lo) begin
            r.value = lo;
            r.ovf   = 1'b1;
        end else begin
            r.value = value;
            r.ovf   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider, q = n / d, radix-2 restoring,
// one quotient bit per clock. Result truncates toward zero and saturates.
//
// Ports:
//   clk_i, rst_n_i        clock / async active-low reset
//   s_valid_i, s_ready_o  operand handshake (n_i, d_i sampled on accept)
//   m_valid_o, m_ready_i  result handshake
//   q_o                   signed quotient (OutWidth, OutPoint frac bits)
//   ovf_o                 quotient clamped to max/min
//   dbz_o                 denominator was zero
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for operands; magnitudes/signs latched on accept
// CALC  | W shift/trial-subtract iterations, counter W-1 down to 0
// DONE  | first cycle finalises sign/saturation into the output
//       | registers; then m_valid_o held until m_ready_i
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int NWidth   = 16,
    parameter int NPoint   = 12,
    parameter int DWidth   = 16,
    parameter int DPoint   = 8,
    parameter int OutWidth = 16,
    parameter int OutPoint = 10
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [NWidth-1:0]   n_i,
    input  logic [DWidth-1:0]   d_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [OutWidth-1:0] q_o,
    output logic                ovf_o,
    output logic                dbz_o
);

    localparam int SHIFT = shift_amt(NPoint, DPoint, OutPoint);
    localparam int W     = NWidth + SHIFT;
    localparam int CNT_W = $clog2(W + 1);

    if (SHIFT < 0) begin : g_bad_shift
        $error("fixed_point_divider: DPoint + OutPoint must be >= NPoint");
    end
    if (W > 63 || OutWidth > 63) begin : g_too_wide
        $error("fixed_point_divider: dividend/quotient wider than 63 bits");
    end

    localparam logic [OutWidth-1:0] QMAX = {1'b0, {(OutWidth-1){1'b1}}};
    localparam logic [OutWidth-1:0] QMIN = {1'b1, {(OutWidth-1){1'b0}}};

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        dq_q, dq_d;     // dividend shifting out, quotient shifting in
    logic [DWidth-1:0]   rem_q, rem_d;
    logic [DWidth-1:0]   div_q, div_d;
    logic                neg_q, neg_d;
    logic                nzero_q, nzero_d;
    logic                opdbz_q, opdbz_d;
    logic                m_valid_q, m_valid_d;
    logic [OutWidth-1:0] q_q, q_d;
    logic                ovf_q, ovf_d;
    logic                dbz_q, dbz_d;

    logic [NWidth-1:0]   n_abs;
    logic [DWidth-1:0]   d_abs;
    logic [DWidth:0]     rem_sh;
    logic [DWidth:0]     rem_sub;
    logic                ge;
    logic signed [63:0]  sval;
    sat_res_t            sat_r;

    always_comb begin
        // Magnitudes as unsigned: negating INT_MIN yields 2^(width-1), which
        // is the correct unsigned magnitude.
        n_abs = n_i[NWidth-1] ? (~n_i + 1'b1) : n_i;
        d_abs = d_i[DWidth-1] ? (~d_i + 1'b1) : d_i;

        // Remainder stays below the divisor, so DWidth bits hold it and one
        // extra bit covers the shifted trial value.
        rem_sh  = {rem_q, dq_q[W-1]};
        ge      = (rem_sh >= {1'b0, div_q});
        rem_sub = ge ? (rem_sh - {1'b0, div_q}) : rem_sh;

        sval  = neg_q ? -$signed(64'(dq_q)) : $signed(64'(dq_q));
        sat_r = sat_signed(sval, OutWidth);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dq_d      = dq_q;
        rem_d     = rem_q;
        div_d     = div_q;
        neg_d     = neg_q;
        nzero_d   = nzero_q;
        opdbz_d   = opdbz_q;
        m_valid_d = m_valid_q;
        q_d       = q_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;

        case (state_q)
            DIV_IDLE: begin
                if (s_valid_i) begin
                    dq_d    = W'(n_abs) << SHIFT;
                    rem_d   = '0;
                    div_d   = d_abs;
                    neg_d   = n_i[NWidth-1] ^ d_i[DWidth-1];
                    nzero_d = (n_i == '0);
                    opdbz_d = (d_i == '0);
                    cnt_d   = CNT_W'(W - 1);
                    state_d = (d_i == '0) ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                rem_d = rem_sub[DWidth-1:0];
                dq_d  = {dq_q[W-2:0], ge};
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_DONE: begin
                if (!m_valid_q) begin
                    m_valid_d = 1'b1;
                    dbz_d     = opdbz_q;
                    if (opdbz_q) begin
                        // With d == 0 the sign flag reduces to sign(n).
                        q_d   = nzero_q ? '0 : (neg_q ? QMIN : QMAX);
                        ovf_d = 1'b0;
                    end else begin
                        q_d   = sat_r.value[OutWidth-1:0];
                        ovf_d = sat_r.ovf;
                    end
                end else if (m_ready_i) begin
                    m_valid_d = 1'b0;
                    state_d   = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            neg_q     <= 1'b0;
            nzero_q   <= 1'b0;
            opdbz_q   <= 1'b0;
            m_valid_q <= 1'b0;
            q_q       <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dq_q      <= dq_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            nzero_q   <= nzero_d;
            opdbz_q   <= opdbz_d;
            m_valid_q <= m_valid_d;
            q_q       <= q_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
        end
    end

    assign s_ready_o = (state_q == DIV_IDLE);
    assign m_valid_o = m_valid_q;
    assign q_o       = q_q;
    assign ovf_o     = ovf_q;
    assign dbz_o     = dbz_q;

endmodule
